// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC command sequencer and ADC control module.
// Command codes, sequencer states and the serial command word type.
package adc_ctrl_pkg;

    localparam logic [7:0] CODE_IDLE    = 8'h00;
    localparam logic [7:0] CODE_BUFFER  = 8'h01;
    localparam logic [7:0] CODE_ISSUE   = 8'h02;
    localparam logic [7:0] CODE_HWRESET = 8'hFF;

    typedef logic [23:0] adc_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RECOV,
        S_BUF,
        S_ISSUE,
        S_GAP
    } seq_state_t;

endpackage

// File: rtl/adc_cmd_fifo.sv
// Single-clock command FIFO holding queued ADC serial register words.
// Full/empty flags and occupancy are derived from one registered count.
module adc_cmd_fifo
    import adc_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  adc_cmd_t               wdata,
    input  logic                   pop,
    output adc_cmd_t               rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    adc_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_cmd_sequencer.sv
// Sequences ADC hardware resets and queued serial register writes onto
// the slow control-command bus, holding each code long enough to sample.
module adc_cmd_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int RESET_HOLD   = 200,
    parameter int RECOVER_HOLD = 2000,
    parameter int BUF_HOLD     = 100,
    parameter int ISSUE_HOLD   = 700,
    parameter int GAP_HOLD     = 100,
    parameter int TMR_W        = 16
) (
    input  logic        clk,
    input  logic        iStateReset,
    input  logic        iHwResetReq,
    input  logic        iCmdValid,
    input  logic [23:0] iCmdData,
    output logic        oCmdReady,
    output logic [7:0]  adc_control_comm,
    output logic [23:0] adc_serial_cmd,
    output logic        oBusy,
    output logic        oCmdDone,
    output logic        oResetDone,
    output logic [15:0] oDoneCount
);

    localparam logic [TMR_W-1:0] T_RST   = TMR_W'(RESET_HOLD - 1);
    localparam logic [TMR_W-1:0] T_RECOV = TMR_W'(RECOVER_HOLD - 1);
    localparam logic [TMR_W-1:0] T_BUF   = TMR_W'(BUF_HOLD - 1);
    localparam logic [TMR_W-1:0] T_ISSUE = TMR_W'(ISSUE_HOLD - 1);
    localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(GAP_HOLD - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       state;
    logic [TMR_W-1:0] timer;
    logic             rst_pending;
    logic [15:0]      done_cnt;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    adc_cmd_t         fifo_rdata;
    logic [CW-1:0]    fifo_count;

    // A pending hardware reset outranks any queued command in idle.
    assign fifo_pop = (state == S_IDLE) & ~rst_pending & ~fifo_empty;

    assign oCmdReady  = ~fifo_full;
    assign oBusy      = (state != S_IDLE) | (fifo_count != '0) | rst_pending;
    assign oDoneCount = done_cnt;

    adc_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (iStateReset),
        .push  (iCmdValid),
        .wdata (iCmdData),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Command FSM: code, word and pulses are registered with the state.
    always_ff @(posedge clk) begin
        if (iStateReset) begin
            state            <= S_IDLE;
            timer            <= '0;
            rst_pending      <= 1'b0;
            done_cnt         <= '0;
            adc_control_comm <= CODE_IDLE;
            adc_serial_cmd   <= '0;
            oCmdDone         <= 1'b0;
            oResetDone       <= 1'b0;
        end else begin
            oCmdDone   <= 1'b0;
            oResetDone <= 1'b0;
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end
            // A new request wins over the clear on entry to S_RST.
            if (iHwResetReq) begin
                rst_pending <= 1'b1;
            end else if (state == S_IDLE && rst_pending) begin
                rst_pending <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (rst_pending) begin
                        state            <= S_RST;
                        timer            <= T_RST;
                        adc_control_comm <= CODE_HWRESET;
                    end else if (!fifo_empty) begin
                        state            <= S_BUF;
                        timer            <= T_BUF;
                        adc_control_comm <= CODE_BUFFER;
                        adc_serial_cmd   <= fifo_rdata;
                    end
                end
                S_RST: begin
                    if (timer == '0) begin
                        state            <= S_RECOV;
                        timer            <= T_RECOV;
                        adc_control_comm <= CODE_IDLE;
                    end
                end
                S_RECOV: begin
                    if (timer == '0) begin
                        state            <= S_IDLE;
                        timer            <= '0;
                        adc_control_comm <= CODE_IDLE;
                        oResetDone       <= 1'b1;
                    end
                end
                S_BUF: begin
                    if (timer == '0) begin
                        state            <= S_ISSUE;
                        timer            <= T_ISSUE;
                        adc_control_comm <= CODE_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (timer == '0) begin
                        state            <= S_GAP;
                        timer            <= T_GAP;
                        adc_control_comm <= CODE_IDLE;
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        state            <= S_IDLE;
                        timer            <= '0;
                        adc_control_comm <= CODE_IDLE;
                        oCmdDone         <= 1'b1;
                        done_cnt         <= done_cnt + 1'b1;
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    timer            <= '0;
                    adc_control_comm <= CODE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Bench for adc_cmd_sequencer: directed scenarios then random traffic,
// every cycle compared against a queue-based schedule model.
module tb_adc_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int RH    = 3;
    localparam int RCH   = 5;
    localparam int BH    = 2;
    localparam int IH    = 6;
    localparam int GH    = 2;

    logic        clk = 1'b0;
    logic        st_rst;
    logic        hw_req;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        cmd_ready;
    logic [7:0]  comm;
    logic [23:0] ser_cmd;
    logic        busy;
    logic        cmd_done;
    logic        rst_done;
    logic [15:0] done_count;

    always #5 clk = ~clk;

    adc_cmd_sequencer #(
        .FIFO_DEPTH   (DEPTH),
        .RESET_HOLD   (RH),
        .RECOVER_HOLD (RCH),
        .BUF_HOLD     (BH),
        .ISSUE_HOLD   (IH),
        .GAP_HOLD     (GH),
        .TMR_W        (16)
    ) dut (
        .clk              (clk),
        .iStateReset      (st_rst),
        .iHwResetReq      (hw_req),
        .iCmdValid        (cmd_valid),
        .iCmdData         (cmd_data),
        .oCmdReady        (cmd_ready),
        .adc_control_comm (comm),
        .adc_serial_cmd   (ser_cmd),
        .oBusy            (busy),
        .oCmdDone         (cmd_done),
        .oResetDone       (rst_done),
        .oDoneCount       (done_count)
    );

    // Model: a FIFO queue plus a queue of per-cycle output slots that is
    // expanded from the hold lengths whenever the sequencer is idle.
    typedef struct packed {
        logic [7:0] code;
        logic       idle;
        logic       rdone;
        logic       cdone;
    } slot_t;

    slot_t       plan[$];
    logic [23:0] fq[$];
    bit          m_pend;
    bit          m_idle = 1'b1;
    logic [7:0]  m_comm;
    logic [23:0] m_ser;
    bit          m_cdone;
    bit          m_rdone;
    logic [15:0] m_cnt;

    int errors = 0;
    int checks = 0;

    function automatic void add_slots(logic [7:0] c, int n);
        for (int i = 0; i < n; i++) begin
            plan.push_back('{c, 1'b0, 1'b0, 1'b0});
        end
    endfunction

    function automatic void model_edge();
        bit    ready_pre;
        bit    dec_rst;
        slot_t s;
        ready_pre = fq.size() < DEPTH;
        dec_rst   = 1'b0;
        if (st_rst) begin
            plan.delete();
            fq.delete();
            m_pend  = 1'b0;
            m_idle  = 1'b1;
            m_comm  = 8'h00;
            m_ser   = '0;
            m_cdone = 1'b0;
            m_rdone = 1'b0;
            m_cnt   = '0;
            return;
        end
        if (m_idle) begin
            if (m_pend) begin
                add_slots(8'hFF, RH);
                add_slots(8'h00, RCH);
                plan.push_back('{8'h00, 1'b1, 1'b1, 1'b0});
                dec_rst = 1'b1;
            end else if (fq.size() > 0) begin
                m_ser = fq.pop_front();
                add_slots(8'h01, BH);
                add_slots(8'h02, IH);
                add_slots(8'h00, GH);
                plan.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
            end
        end
        if (cmd_valid && ready_pre) begin
            fq.push_back(cmd_data);
        end
        if (hw_req) begin
            m_pend = 1'b1;
        end else if (dec_rst) begin
            m_pend = 1'b0;
        end
        if (plan.size() > 0) begin
            s       = plan.pop_front();
            m_comm  = s.code;
            m_idle  = s.idle;
            m_rdone = s.rdone;
            m_cdone = s.cdone;
            if (s.cdone) begin
                m_cnt = m_cnt + 16'd1;
            end
        end else begin
            m_comm  = 8'h00;
            m_idle  = 1'b1;
            m_rdone = 1'b0;
            m_cdone = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("comm", 32'(comm), 32'(m_comm));
        chk("serial_cmd", 32'(ser_cmd), 32'(m_ser));
        chk("cmd_ready", 32'(cmd_ready), 32'(fq.size() < DEPTH));
        chk("busy", 32'(busy),
            32'(!m_idle || fq.size() > 0 || m_pend));
        chk("cmd_done", 32'(cmd_done), 32'(m_cdone));
        chk("reset_done", 32'(rst_done), 32'(m_rdone));
        chk("done_count", 32'(done_count), 32'(m_cnt));
    endtask

    task automatic tick(input logic v, input logic [23:0] d,
                        input logic hr, input logic sr);
        cmd_valid = v;
        cmd_data  = d;
        hw_req    = hr;
        st_rst    = sr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    // Host honours ready: holds the word until a cycle with ready high.
    task automatic push_wait(input logic [23:0] w);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            acc = cmd_ready;
            tick(1'b1, w, 1'b0, 1'b0);
            n++;
        end
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    initial begin
        st_rst    = 1'b1;
        hw_req    = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;

        tick(1'b0, 24'h0, 1'b0, 1'b1);
        tick(1'b0, 24'h0, 1'b0, 1'b1);
        chk("reset_comm", 32'(comm), 32'h00);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(done_count), 32'd0);

        // Single command
        tick(1'b1, 24'h0A1234, 1'b0, 1'b0);
        idle(14);
        chk("single_count", 32'(done_count), 32'd1);

        // Hardware reset requested together with a queued command
        tick(1'b1, 24'h000001, 1'b1, 1'b0);
        idle(22);
        chk("hwrst_count", 32'(done_count), 32'd2);

        // Reset request during ISSUE of the first of two commands
        tick(1'b1, 24'h111111, 1'b0, 1'b0);
        tick(1'b1, 24'h222222, 1'b0, 1'b0);
        idle(4);
        tick(1'b0, 24'h0, 1'b1, 1'b0);
        idle(40);
        chk("midreq_count", 32'(done_count), 32'd4);

        // Backpressure: FSM held in reset sequence while nine words arrive
        tick(1'b0, 24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            push_wait(24'h300000 + 24'(i));
        end
        idle(9 * 11 + 15);
        chk("full_count", 32'(done_count), 32'd13);

        // Sequencer reset mid-ISSUE with two commands still queued
        tick(1'b1, 24'h400001, 1'b0, 1'b0);
        tick(1'b1, 24'h400002, 1'b0, 1'b0);
        tick(1'b1, 24'h400003, 1'b0, 1'b0);
        idle(3);
        tick(1'b0, 24'h0, 1'b0, 1'b1);
        chk("abort_comm", 32'(comm), 32'h00);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(done_count), 32'd0);
        tick(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        idle(12);
        chk("fresh_count", 32'(done_count), 32'd1);

        // Counter wrap from a preloaded value
        force dut.done_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.done_cnt;
        tick(1'b1, 24'h500001, 1'b0, 1'b0);
        tick(1'b1, 24'h500002, 1'b0, 1'b0);
        idle(25);
        chk("wrap_count", 32'(done_count), 32'h0000);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 3) == 0, 24'($urandom),
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 999) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
